// File: rtl/mem_map_pkg.sv
// Address map, region decode and arbiter state shared by the memory controller.
package mem_map_pkg;

    localparam logic [15:0] RAM_BASE   = 16'h0000;
    localparam logic [15:0] RAM_LIMIT  = 16'h3FFF;
    localparam logic [15:0] VRAM_BASE  = 16'h4000;
    localparam logic [15:0] VRAM_LIMIT = 16'h5FFF;
    localparam logic [15:0] KBD_ADDR   = 16'h6000;

    localparam int RAM_WORDS  = 16384;
    localparam int VRAM_WORDS = 8192;
    localparam int VRAM_AW    = 13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VIDEO,
        ST_WINDOW
    } arb_state_t;

    typedef enum logic [1:0] {
        RG_RAM,
        RG_VRAM,
        RG_KBD,
        RG_NONE
    } region_t;

    // RAM_BASE is zero, so the RAM test only needs the upper limit.
    function automatic region_t decode_region(input logic [15:0] a);
        if (a <= RAM_LIMIT)
            return RG_RAM;
        else if (a >= VRAM_BASE && a <= VRAM_LIMIT)
            return RG_VRAM;
        else if (a == KBD_ADDR)
            return RG_KBD;
        else
            return RG_NONE;
    endfunction

endpackage

// File: rtl/vram.sv
// Single-port 8K x16 synchronous video RAM, 1-cycle read latency, read-first.
module vram
    import mem_map_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [VRAM_AW-1:0] addr,
    input  logic [15:0]        wdata,
    output logic [15:0]        rdata
);

    logic [15:0] mem [0:VRAM_WORDS-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_controller.sv
// CPU memory map (RAM/VRAM/KBD) with a burst arbiter sharing VRAM with video scanout.
// Optional MEM_FAULT_EN adds a sticky mem_fault output for unmapped or KBD-write accesses.
module mem_controller
    import mem_map_pkg::*;
#(
    parameter int BURST_MAX  = 32,
    parameter int CPU_WINDOW = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_load,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_busy,
    input  logic        vid_req,
    input  logic [12:0] vid_address,
    output logic [15:0] vid_rdata,
    output logic        vid_valid,
    input  logic [15:0] keyboard
`ifdef MEM_FAULT_EN
    ,
    output logic        mem_fault
`endif
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int WW = $clog2(CPU_WINDOW + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
    // The IDLE hop after WINDOW is itself a non-busy cycle, so WINDOW lasts
    // CPU_WINDOW-1 cycles and the CPU sees CPU_WINDOW free cycles in total.
    localparam logic [WW-1:0] WIN_LAST = WW'((CPU_WINDOW > 2) ? CPU_WINDOW - 2 : 0);

    arb_state_t    state, state_d;
    logic [BW-1:0] burst_cnt, burst_d;
    logic [WW-1:0] win_cnt, win_d;

    region_t              region;
    logic                 vram_we;
    logic [VRAM_AW-1:0]   vram_addr;
    logic [15:0]          vram_q;
    logic [15:0]          ram [0:RAM_WORDS-1];

    assign region    = decode_region(cpu_address);
    assign cpu_busy  = (state == ST_VIDEO);
    assign vram_addr = cpu_busy ? vid_address : cpu_address[VRAM_AW-1:0];
    assign vram_we   = cpu_load && (region == RG_VRAM) && !cpu_busy;
    assign vid_rdata = vid_valid ? vram_q : 16'h0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            win_cnt   <= '0;
        end else begin
            state     <= state_d;
            burst_cnt <= burst_d;
            win_cnt   <= win_d;
        end
    end

    always_comb begin
        state_d = state;
        burst_d = burst_cnt;
        win_d   = win_cnt;
        case (state)
            ST_IDLE: begin
                if (vid_req) begin
                    state_d = ST_VIDEO;
                    burst_d = '0;
                end
            end
            ST_VIDEO: begin
                if (!vid_req || burst_cnt == BURST_LAST) begin
                    state_d = ST_WINDOW;
                    burst_d = '0;
                    win_d   = '0;
                end else begin
                    burst_d = burst_cnt + 1'b1;
                end
            end
            ST_WINDOW: begin
                if (win_cnt == WIN_LAST) begin
                    state_d = ST_IDLE;
                    win_d   = '0;
                end else begin
                    win_d = win_cnt + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    vram u_vram (
        .clk   (clk),
        .we    (vram_we),
        .addr  (vram_addr),
        .wdata (cpu_wdata),
        .rdata (vram_q)
    );

    always_ff @(posedge clk) begin
        if (cpu_load && region == RG_RAM)
            ram[cpu_address[13:0]] <= cpu_wdata;
    end

    // VRAM data already carries one cycle of latency in vram_q, so a stable
    // VRAM address lands here two cycles after it is first presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata <= 16'h0000;
            vid_valid <= 1'b0;
        end else begin
            vid_valid <= (state == ST_VIDEO);
            case (region)
                RG_RAM:  cpu_rdata <= ram[cpu_address[13:0]];
                RG_VRAM: cpu_rdata <= vram_q;
                RG_KBD:  cpu_rdata <= keyboard;
                default: cpu_rdata <= 16'h0000;
            endcase
        end
    end

`ifdef MEM_FAULT_EN
    always_ff @(posedge clk) begin
        if (reset)
            mem_fault <= 1'b0;
        else if (region == RG_NONE || (region == RG_KBD && cpu_load))
            mem_fault <= 1'b1;
    end
`endif

endmodule

// File: doc/mem_controller.md
MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 Parameter BURST_MAX, default 32: maximum consecutive video words per VRAM grant.
REQ-002 Parameter CPU_WINDOW, default 4: minimum consecutive non-busy cycles after each video grant.
REQ-003 Port clk, input, 1: sole clock; all logic on posedge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port cpu_load, input, 1: CPU write strobe.
REQ-006 Port cpu_address, input, 16: CPU word address.
REQ-007 Port cpu_wdata, input, 16: CPU write data.
REQ-008 Port cpu_rdata, output, 16: CPU read data.
REQ-009 Port cpu_busy, output, 1: VRAM owned by video; CPU VRAM access stalls.
REQ-010 Port vid_req, input, 1: video scanout requests VRAM.
REQ-011 Port vid_address, input, 13: VRAM word offset for video.
REQ-012 Port vid_rdata, output, 16: video read data.
REQ-013 Port vid_valid, output, 1: vid_rdata valid this cycle.
REQ-014 Port keyboard, input, 16: current key code.

Function
REQ-015 Address map: RAM 0x0000-0x3FFF (16K x16); VRAM 0x4000-0x5FFF (8K x16); KBD 0x6000; all others unmapped.
REQ-016 RAM read: cpu_rdata equals RAM[cpu_address] one cycle after cpu_address is presented.
REQ-017 RAM write: commits in the same cycle as cpu_load=1 with a RAM address; never stalled.
REQ-018 KBD read: cpu_rdata equals keyboard, registered, with 1-cycle latency; writes to KBD are ignored.
REQ-019 Unmapped reads return 0x0000 after 1 cycle; unmapped writes are ignored.
REQ-020 Arbiter states: IDLE, VIDEO, WINDOW.
REQ-021 IDLE: cpu_busy=0; if vid_req=1, next state is VIDEO.
REQ-022 VIDEO: cpu_busy=1; each cycle reads VRAM[vid_address]; burst counter increments each cycle.
REQ-023 VIDEO exits to WINDOW when vid_req=0 or when the burst counter reaches BURST_MAX-1.
REQ-024 WINDOW: cpu_busy=0; window counter counts CPU_WINDOW cycles, then state goes to IDLE.
REQ-025 vid_valid=1 exactly one cycle after each VIDEO cycle, with vid_rdata = VRAM word read.
REQ-026 In IDLE and WINDOW, the VRAM port reads cpu_address[12:0].
REQ-027 cpu_rdata for VRAM is valid 2 cycles after the first non-busy cycle with a stable address (VRAM read register plus output register).
REQ-028 A VRAM write commits only in a cycle with cpu_load=1, VRAM address, and cpu_busy=0.
REQ-029 A VRAM write with cpu_busy=1 is held off; the CPU keeps cpu_load asserted until busy falls.
REQ-030 vid_req rising in the same cycle as a committed CPU VRAM write: the write commits first; VIDEO starts the next cycle.
REQ-031 vid_req is ignored during WINDOW; video cannot re-enter VIDEO until WINDOW completes.

Reset
REQ-032 Reset sets state=IDLE, both counters=0, cpu_busy=0, vid_valid=0, cpu_rdata=0, vid_rdata=0.
REQ-033 Reset mid-burst aborts the burst; no vid_valid is issued in the following cycle.
REQ-034 RAM and VRAM contents are not cleared by reset.

Configuration
REQ-035 Macro MEM_FAULT_EN, when defined, adds an output mem_fault (1 bit) that goes sticky-high on any unmapped CPU read or write, or any write to KBD.
REQ-036 mem_fault is cleared only by reset.
REQ-037 Without MEM_FAULT_EN, the port and its logic are absent; all other behaviour is identical.

Structure
REQ-038 Package mem_map_pkg holds region base/limit constants, the KBD address, and the arbiter state enum.
REQ-039 Sub-module vram: single-port 8K x16 synchronous BRAM, 1-cycle read latency, write-enable.
REQ-040 RAM is inferred inline.

Verification
REQ-041 Write 0x1234 to 0x0010, then read 0x0010 -> cpu_rdata=0x1234 one cycle later; cpu_busy stays 0.
REQ-042 vid_req held for 40 cycles -> cpu_busy high for exactly 32 cycles, then low for 4, then high again; vid_valid pulses for 32 cycles.
REQ-043 Hold a CPU write of 0xBEEF to 0x4005 asserted during VIDEO -> it commits in the first WINDOW cycle; a subsequent video read of offset 5 returns 0xBEEF.
REQ-044 CPU read of 0x4005 issued while busy -> correct data on cpu_rdata 2 cycles after busy falls, still within WINDOW.
REQ-045 keyboard=0x0041, read 0x6000 -> 0x0041; read 0x7000 -> 0x0000 and mem_fault=1 (MEM_FAULT_EN defined).
REQ-046 Assert reset in the 10th VIDEO cycle -> next cycle state=IDLE, cpu_busy=0, vid_valid=0.
